// File: rtl/cache_line_adapter_if.sv
// cache_line_adapter_if: controller line port and memory beat port of the line adapter.
interface cache_line_adapter_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int BEAT_W = 32
);
   logic              line_read;
   logic              line_write;
   logic [ADDR_W-1:0] line_addr;
   logic [LINE_W-1:0] line_wdata;
   logic [LINE_W-1:0] line_rdata;
   logic              line_resp;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [BEAT_W-1:0] mem_wdata;
   logic [BEAT_W-1:0] mem_rdata;
   logic              mem_ack;
   modport master (
      output line_read, line_write, line_addr, line_wdata, mem_rdata, mem_ack,
      input  line_rdata, line_resp, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      input  line_read, line_write, line_addr, line_wdata, mem_rdata, mem_ack,
      output line_rdata, line_resp, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_line_adapter.sv
// cache_line_adapter: splits one line fill/write-back into a burst of req/ack memory beats.
module cache_line_adapter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int BEAT_W = 32
) (
   input logic                clk,
   input logic                rst,
   cache_line_adapter_if.slave bus
);
   localparam int BEATS = LINE_W / BEAT_W;
   localparam int OFF   = $clog2(LINE_W / 8);
   localparam int BOFF  = $clog2(BEAT_W / 8);
   localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0]     LAST  = CW'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LMASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

   typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [LINE_W-1:0] buf_q, buf_d;
   logic [ADDR_W-1:0] base_q, base_d;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         base_q  <= base_d;
      end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      base_d  = base_q;
      case (state_q)
         IDLE:
            if (bus.line_write || bus.line_read) begin
               state_d = bus.line_write ? WB : FILL;
               base_d  = bus.line_addr & LMASK;
               buf_d   = bus.line_write ? bus.line_wdata : buf_q;
               cnt_d   = '0;
            end
         WB, FILL:
            if (bus.mem_ack) begin
               if (state_q == FILL) buf_d[cnt_q*BEAT_W +: BEAT_W] = bus.mem_rdata;
               cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
               state_d = cnt_q == LAST ? RESP : state_q;
            end
         default: state_d = IDLE;
      endcase
   end

   // base is line-aligned, so OR-ing in the beat offset never carries out of the line
   assign bus.mem_addr   = base_q | (ADDR_W'(cnt_q) << BOFF);
   assign bus.mem_wdata  = buf_q[cnt_q*BEAT_W +: BEAT_W];
   assign bus.mem_req    = state_q == WB || state_q == FILL;
   assign bus.mem_we     = state_q == WB;
   assign bus.line_resp  = state_q == RESP;
   assign bus.line_rdata = buf_q;
endmodule

// File: tb/tb_cache_line_adapter.sv
// tb_cache_line_adapter: randomized line transfers checked against a beat-level reference model.
module tb_cache_line_adapter;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;
   localparam int BEAT_W = 32;
   localparam int BEATS  = LINE_W / BEAT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [LINE_W-1:0] last_line = '0;

   always #5 clk = ~clk;

   cache_line_adapter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();
   cache_line_adapter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_req"}, bus.mem_req, 0);
      chk({tag, "_we"}, bus.mem_we, 0);
      chk({tag, "_resp"}, bus.line_resp, 0);
   endtask

   task automatic do_line(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] wdata, input int lo, input int hi);
      logic [ADDR_W-1:0] base;
      logic [LINE_W-1:0] exp_line;
      logic [BEAT_W-1:0] beat;
      int t, stalls, st;
      base = addr & 16'hFFF0;
      exp_line = wr ? wdata : last_line;
      t = 0;
      stalls = 0;
      @(negedge clk);
      chk_quiet("pre");
      bus.line_read  = rd;
      bus.line_write = wr;
      bus.line_addr  = addr;
      bus.line_wdata = wdata;
      bus.mem_ack    = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         st = $urandom_range(hi, lo);
         stalls += st;
         for (int s = 0; s <= st; s++) begin
            @(negedge clk);
            t++;
            chk("beat_req", bus.mem_req, 1);
            chk("beat_we", bus.mem_we, wr);
            chk("beat_addr", bus.mem_addr, base + ADDR_W'(k * (BEAT_W / 8)));
            chk("beat_resp", bus.line_resp, 0);
            if (wr) chk("beat_wdata", bus.mem_wdata, wdata[k*BEAT_W +: BEAT_W]);
            beat = $urandom;
            bus.mem_rdata = beat;
            bus.mem_ack   = (s == st);
            if (s == st && !wr) exp_line[k*BEAT_W +: BEAT_W] = beat;
         end
      end
      @(negedge clk);
      t++;
      bus.mem_ack = 1'b0;
      chk("resp", bus.line_resp, 1);
      chk("resp_req", bus.mem_req, 0);
      chk("latency", t, BEATS + 1 + stalls);
      chk("line_rdata", bus.line_rdata, exp_line);
      bus.line_read  = 1'b0;
      bus.line_write = 1'b0;
      last_line = exp_line;
      @(negedge clk);
      chk_quiet("post");
      chk("post_rdata", bus.line_rdata, exp_line);
   endtask

   initial begin
      bus.line_read  = 1'b0;
      bus.line_write = 1'b0;
      bus.line_addr  = '0;
      bus.line_wdata = '0;
      bus.mem_rdata  = '0;
      bus.mem_ack    = 1'b0;
      repeat (2) @(negedge clk);
      chk_quiet("rst");
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_rdata", bus.line_rdata, 0);
      rst = 1'b0;

      do_line(1, 0, 16'h1234, '0, 0, 0);
      do_line(0, 1, 16'h2000, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 0);
      do_line(1, 0, 16'h4568, '0, 3, 3);
      do_line(1, 1, 16'h7777, {$urandom, $urandom, $urandom, $urandom}, 0, 1);

      // abort a fill after its second beat is accepted
      @(negedge clk);
      bus.line_read = 1'b1;
      bus.line_addr = 16'h3450;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_addr", bus.mem_addr, 16'h3450 + ADDR_W'(k * 4));
         bus.mem_rdata = $urandom;
         bus.mem_ack   = (k < 2);
      end
      #2 rst = 1'b1;
      #1;
      chk_quiet("abort");
      chk("abort_addr0", bus.mem_addr, 0);
      chk("abort_wdata", bus.mem_wdata, 0);
      chk("abort_rdata", bus.line_rdata, 0);
      bus.line_read = 1'b0;
      bus.mem_ack   = 1'b0;
      last_line = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk_quiet("after_abort");
      end
      do_line(1, 0, 16'h9ABC, '0, 0, 1);

      repeat (6) begin
         @(negedge clk);
         chk_quiet("spur");
         chk("spur_rdata", bus.line_rdata, last_line);
         bus.mem_ack   = $urandom_range(1, 0);
         bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk_quiet("spur_end");
      chk("spur_end_rdata", bus.line_rdata, last_line);

      for (int i = 0; i < 20; i++) begin
         bit rd, wr;
         rd = $urandom_range(1, 0);
         wr = !rd || $urandom_range(1, 0);
         do_line(rd, wr, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0, 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
